alu_pair_seq: RTL and testbench

- Multi-chunk ALU sequencer that wraps the existing 8-bit combinational alu.
- Performs wide operations by issuing one ALU operation per cycle, chunk by chunk, chaining carry through C.
- Drives the alu inputs, consumes its outputs, and assembles the wide result and flags.
- Sits between the execute-stage decode and the register writeback.

---
 rtl/alu_pair_seq_if.sv | 69 ++++++
 rtl/alu_pair_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_pair_seq.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pair_seq_if.sv
// Request/result bus between execute-stage decode and the alu_pair_seq sequencer,
// plus fallback definitions of the shared alu opcode and flag constants.
// Optional start_err member is present when ALU_PAIR_SEQ_START_ERR_EN is defined.

`ifndef CONST_ALU_OPER_WIDTH
`define CONST_ALU_OPER_WIDTH 4
`endif
`ifndef CONST_ALU_INOUT_WIDTH
`define CONST_ALU_INOUT_WIDTH 8
`endif
`ifndef CONST_PROC_FLAGS_WIDTH
`define CONST_PROC_FLAGS_WIDTH 4
`endif
`ifndef CONST_PROC_FLAGS_C_BIT
`define CONST_PROC_FLAGS_C_BIT 0
`define CONST_PROC_FLAGS_Z_BIT 1
`define CONST_PROC_FLAGS_N_BIT 2
`define CONST_PROC_FLAGS_V_BIT 3
`endif
`ifndef ENUM_ALU_OPER_ADD
`define ENUM_ALU_OPER_ADD 4'd0
`define ENUM_ALU_OPER_ADC 4'd1
`define ENUM_ALU_OPER_SUB 4'd2
`define ENUM_ALU_OPER_SBC 4'd3
`define ENUM_ALU_OPER_AND 4'd4
`define ENUM_ALU_OPER_ORR 4'd5
`define ENUM_ALU_OPER_XOR 4'd6
`define ENUM_ALU_OPER_CMP 4'd7
`define ENUM_ALU_OPER_LSL 4'd8
`define ENUM_ALU_OPER_LSR 4'd9
`define ENUM_ALU_OPER_ASR 4'd10
`define ENUM_ALU_OPER_ROL 4'd11
`define ENUM_ALU_OPER_ROR 4'd12
`endif

interface alu_pair_seq_if #(
    parameter int WIDTH = 16
);
    logic                               start;
    logic [`CONST_ALU_OPER_WIDTH-1:0]   oper;
    logic [WIDTH-1:0]                   a_in;
    logic [WIDTH-1:0]                   b_in;
    logic [`CONST_PROC_FLAGS_WIDTH-1:0] proc_flags_in;
    logic                               busy;
    logic                               done;
    logic [WIDTH-1:0]                   out;
    logic [`CONST_PROC_FLAGS_WIDTH-1:0] proc_flags_out;
`ifdef ALU_PAIR_SEQ_START_ERR_EN
    logic                               start_err;

    modport master (
        output start, oper, a_in, b_in, proc_flags_in,
        input  busy, done, out, proc_flags_out, start_err
    );
    modport slave (
        input  start, oper, a_in, b_in, proc_flags_in,
        output busy, done, out, proc_flags_out, start_err
    );
`else
    modport master (
        output start, oper, a_in, b_in, proc_flags_in,
        input  busy, done, out, proc_flags_out
    );
    modport slave (
        input  start, oper, a_in, b_in, proc_flags_in,
        output busy, done, out, proc_flags_out
    );
`endif
endinterface

// File: rtl/alu_pair_seq.sv
// Multi-chunk sequencer around the 8-bit combinational alu: one alu step per cycle,
// carry chained chunk to chunk. Define ALU_PAIR_SEQ_START_ERR_EN to add start_err.

module alu_pair_seq #(
    parameter int CHUNK_WIDTH = `CONST_ALU_INOUT_WIDTH,
    parameter int NUM_CHUNKS  = 2
) (
    input  logic                               master_clk,
    input  logic                               reset,
    alu_pair_seq_if.slave                      bus,
    output logic [`CONST_ALU_OPER_WIDTH-1:0]   alu_oper,
    output logic [CHUNK_WIDTH-1:0]             alu_a_in,
    output logic [CHUNK_WIDTH-1:0]             alu_b_in,
    output logic [`CONST_PROC_FLAGS_WIDTH-1:0] alu_proc_flags_in,
    input  logic [CHUNK_WIDTH-1:0]             alu_out,
    input  logic [`CONST_PROC_FLAGS_WIDTH-1:0] alu_proc_flags_out
);
    localparam int WIDE  = CHUNK_WIDTH * NUM_CHUNKS;
    localparam int OPW   = `CONST_ALU_OPER_WIDTH;
    localparam int FW    = `CONST_PROC_FLAGS_WIDTH;
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [OPW-1:0]   oper_q;
    logic [WIDE-1:0]  a_q, b_q, acc_q, acc_d, out_q, wide_result;
    logic [FW-1:0]    flags_q, flags_out_q, wide_flags;
    logic [IDX_W-1:0] step_q, chunk_idx;
    logic             c_q, v_q;
    logic             accept, last_step, msb_step, first_step;
    logic             use_b, shift_right, op_valid, alu_c, alu_v, final_v;
    logic             unused_alu_flags;

    assign accept     = bus.start && (state_q != S_RUN);
    assign first_step = (step_q == '0);
    assign last_step  = (step_q == LAST_IDX);
    assign alu_c      = alu_proc_flags_out[`CONST_PROC_FLAGS_C_BIT];
    assign alu_v      = alu_proc_flags_out[`CONST_PROC_FLAGS_V_BIT];
    assign unused_alu_flags = ^alu_proc_flags_out;

    assign bus.busy           = (state_q == S_RUN);
    assign bus.done           = (state_q == S_DONE);
    assign bus.out            = out_q;
    assign bus.proc_flags_out = flags_out_q;

    always_ff @(posedge master_clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-step alu opcode: the first step of a chained op uses the unchained form.
    always_comb begin
        alu_oper    = oper_q;
        use_b       = 1'b1;
        shift_right = 1'b0;
        op_valid    = 1'b1;
        case (oper_q)
            `ENUM_ALU_OPER_ADD: alu_oper = first_step ? `ENUM_ALU_OPER_ADD : `ENUM_ALU_OPER_ADC;
            `ENUM_ALU_OPER_SUB,
            `ENUM_ALU_OPER_CMP: alu_oper = first_step ? `ENUM_ALU_OPER_SUB : `ENUM_ALU_OPER_SBC;
            `ENUM_ALU_OPER_ADC, `ENUM_ALU_OPER_SBC,
            `ENUM_ALU_OPER_AND, `ENUM_ALU_OPER_ORR, `ENUM_ALU_OPER_XOR: ;
            `ENUM_ALU_OPER_LSL: begin
                alu_oper = first_step ? `ENUM_ALU_OPER_LSL : `ENUM_ALU_OPER_ROL;
                use_b    = 1'b0;
            end
            `ENUM_ALU_OPER_ROL: use_b = 1'b0;
            `ENUM_ALU_OPER_LSR: begin
                alu_oper    = first_step ? `ENUM_ALU_OPER_LSR : `ENUM_ALU_OPER_ROR;
                use_b       = 1'b0;
                shift_right = 1'b1;
            end
            `ENUM_ALU_OPER_ASR: begin
                alu_oper    = first_step ? `ENUM_ALU_OPER_ASR : `ENUM_ALU_OPER_ROR;
                use_b       = 1'b0;
                shift_right = 1'b1;
            end
            `ENUM_ALU_OPER_ROR: begin
                use_b       = 1'b0;
                shift_right = 1'b1;
            end
            default: begin
                alu_oper = `ENUM_ALU_OPER_ADD;
                op_valid = 1'b0;
            end
        endcase
    end

    assign chunk_idx = shift_right ? (LAST_IDX - step_q) : step_q;
    assign msb_step  = (chunk_idx == LAST_IDX);
    assign alu_a_in  = a_q[int'(chunk_idx)*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign alu_b_in  = use_b ? b_q[int'(chunk_idx)*CHUNK_WIDTH +: CHUNK_WIDTH] : '0;
    assign final_v   = msb_step ? alu_v : v_q;

    always_comb begin
        alu_proc_flags_in = '0;
        alu_proc_flags_in[`CONST_PROC_FLAGS_C_BIT] = c_q;
    end

    // Result as it will stand after this step; used for the final commit and flags.
    always_comb begin
        acc_d = acc_q;
        acc_d[int'(chunk_idx)*CHUNK_WIDTH +: CHUNK_WIDTH] = alu_out;

        wide_flags = '0;
        wide_flags[`CONST_PROC_FLAGS_C_BIT] = alu_c;
        wide_flags[`CONST_PROC_FLAGS_Z_BIT] = (acc_d == '0);
        wide_flags[`CONST_PROC_FLAGS_N_BIT] = acc_d[WIDE-1];
        wide_flags[`CONST_PROC_FLAGS_V_BIT] = final_v;
        wide_result = (oper_q == `ENUM_ALU_OPER_CMP) ? out_q : acc_d;
        if (!op_valid) begin
            wide_flags  = flags_q;
            wide_result = '0;
        end
    end

    // NOTE: operand latches carry no reset; they are always rewritten on an
    // accepted start before being read, so resetting them buys nothing.
    always_ff @(posedge master_clk) begin
        if (accept) begin
            oper_q  <= bus.oper;
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            flags_q <= bus.proc_flags_in;
        end
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            step_q      <= '0;
            acc_q       <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            out_q       <= '0;
            flags_out_q <= '0;
        end else if (accept) begin
            step_q <= '0;
            c_q    <= bus.proc_flags_in[`CONST_PROC_FLAGS_C_BIT];
        end else if (state_q == S_RUN) begin
            acc_q  <= acc_d;
            c_q    <= alu_c;
            step_q <= step_q + IDX_W'(1);
            if (msb_step) v_q <= alu_v;
            if (last_step) begin
                out_q       <= wide_result;
                flags_out_q <= wide_flags;
            end
        end
    end

`ifdef ALU_PAIR_SEQ_START_ERR_EN
    logic start_err_q;

    always_ff @(posedge master_clk) begin
        if (reset) start_err_q <= 1'b0;
        else       start_err_q <= bus.start && (state_q == S_RUN);
    end

    assign bus.start_err = start_err_q;
`endif
endmodule

// File: tb/tb_alu_pair_seq.sv
// Self-checking bench for alu_pair_seq: behavioural 8-bit alu, wide reference model
// and a scoreboard queue of expected results popped on each done pulse.

module tb_alu_pair_seq;
    localparam int CW  = 8;
    localparam int NC  = 2;
    localparam int W   = CW * NC;
    localparam int OPW = `CONST_ALU_OPER_WIDTH;
    localparam int FW  = `CONST_PROC_FLAGS_WIDTH;
    localparam int CB  = `CONST_PROC_FLAGS_C_BIT;
    localparam int ZB  = `CONST_PROC_FLAGS_Z_BIT;
    localparam int NB  = `CONST_PROC_FLAGS_N_BIT;
    localparam int VB  = `CONST_PROC_FLAGS_V_BIT;

    typedef struct packed {
        logic [W-1:0]  out;
        logic [FW-1:0] flags;
    } exp_t;

    logic master_clk = 1'b0;
    logic reset      = 1'b1;
    always #5 master_clk = ~master_clk;

    alu_pair_seq_if #(.WIDTH(W)) bus ();

    logic [OPW-1:0] alu_oper;
    logic [CW-1:0]  alu_a_in, alu_b_in, alu_out;
    logic [FW-1:0]  alu_proc_flags_in, alu_proc_flags_out;

    alu_pair_seq #(.CHUNK_WIDTH(CW), .NUM_CHUNKS(NC)) dut (
        .master_clk         (master_clk),
        .reset              (reset),
        .bus                (bus),
        .alu_oper           (alu_oper),
        .alu_a_in           (alu_a_in),
        .alu_b_in           (alu_b_in),
        .alu_proc_flags_in  (alu_proc_flags_in),
        .alu_out            (alu_out),
        .alu_proc_flags_out (alu_proc_flags_out)
    );

    // Behavioural stand-in for the 8-bit alu.
    logic [CW:0]   m_sum;
    logic [CW-1:0] m_bb;
    logic          m_cin, m_c, m_v, m_arith;
    always_comb begin
        m_cin   = alu_proc_flags_in[CB];
        m_bb    = alu_b_in;
        m_sum   = '0;
        m_c     = m_cin;
        m_v     = 1'b0;
        m_arith = 1'b0;
        alu_out = '0;
        case (alu_oper)
            `ENUM_ALU_OPER_ADD: begin m_sum = {1'b0, alu_a_in} + {1'b0, m_bb}; m_arith = 1'b1; end
            `ENUM_ALU_OPER_ADC: begin m_sum = {1'b0, alu_a_in} + {1'b0, m_bb} + {{CW{1'b0}}, m_cin}; m_arith = 1'b1; end
            `ENUM_ALU_OPER_SUB,
            `ENUM_ALU_OPER_CMP: begin m_bb = ~alu_b_in; m_sum = {1'b0, alu_a_in} + {1'b0, m_bb} + 1'b1; m_arith = 1'b1; end
            `ENUM_ALU_OPER_SBC: begin m_bb = ~alu_b_in; m_sum = {1'b0, alu_a_in} + {1'b0, m_bb} + {{CW{1'b0}}, m_cin}; m_arith = 1'b1; end
            `ENUM_ALU_OPER_AND: alu_out = alu_a_in & alu_b_in;
            `ENUM_ALU_OPER_ORR: alu_out = alu_a_in | alu_b_in;
            `ENUM_ALU_OPER_XOR: alu_out = alu_a_in ^ alu_b_in;
            `ENUM_ALU_OPER_LSL: begin alu_out = {alu_a_in[CW-2:0], 1'b0};  m_c = alu_a_in[CW-1]; end
            `ENUM_ALU_OPER_ROL: begin alu_out = {alu_a_in[CW-2:0], m_cin}; m_c = alu_a_in[CW-1]; end
            `ENUM_ALU_OPER_LSR: begin alu_out = {1'b0, alu_a_in[CW-1:1]};  m_c = alu_a_in[0]; end
            `ENUM_ALU_OPER_ASR: begin alu_out = {alu_a_in[CW-1], alu_a_in[CW-1:1]}; m_c = alu_a_in[0]; end
            `ENUM_ALU_OPER_ROR: begin alu_out = {m_cin, alu_a_in[CW-1:1]}; m_c = alu_a_in[0]; end
            default: ;
        endcase
        if (m_arith) begin
            alu_out = m_sum[CW-1:0];
            m_c     = m_sum[CW];
            m_v     = (alu_a_in[CW-1] == m_bb[CW-1]) && (m_sum[CW-1] != alu_a_in[CW-1]);
        end
        alu_proc_flags_out     = '0;
        alu_proc_flags_out[CB] = m_c;
        alu_proc_flags_out[ZB] = (alu_out == '0);
        alu_proc_flags_out[NB] = alu_out[CW-1];
        alu_proc_flags_out[VB] = m_v;
    end

    // Whole-word reference for the wide operation.
    function automatic exp_t ref_model(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [FW-1:0] f,
                                       input logic [W-1:0] prev);
        logic [W:0]   s;
        logic [W-1:0] bb, r;
        logic         cin, c, v, arith;
        exp_t         e;
        cin = f[CB]; c = cin; v = 1'b0; arith = 1'b0; bb = b; r = '0; s = '0;
        case (op)
            `ENUM_ALU_OPER_ADD: begin s = {1'b0, a} + {1'b0, b}; arith = 1'b1; end
            `ENUM_ALU_OPER_ADC: begin s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}; arith = 1'b1; end
            `ENUM_ALU_OPER_SUB,
            `ENUM_ALU_OPER_CMP: begin bb = ~b; s = {1'b0, a} + {1'b0, bb} + 1'b1; arith = 1'b1; end
            `ENUM_ALU_OPER_SBC: begin bb = ~b; s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin}; arith = 1'b1; end
            `ENUM_ALU_OPER_AND: r = a & b;
            `ENUM_ALU_OPER_ORR: r = a | b;
            `ENUM_ALU_OPER_XOR: r = a ^ b;
            `ENUM_ALU_OPER_LSL: begin r = {a[W-2:0], 1'b0}; c = a[W-1]; end
            `ENUM_ALU_OPER_ROL: begin r = {a[W-2:0], cin};  c = a[W-1]; end
            `ENUM_ALU_OPER_LSR: begin r = {1'b0, a[W-1:1]}; c = a[0]; end
            `ENUM_ALU_OPER_ASR: begin r = {a[W-1], a[W-1:1]}; c = a[0]; end
            `ENUM_ALU_OPER_ROR: begin r = {cin, a[W-1:1]};  c = a[0]; end
            default: begin
                e.out   = '0;
                e.flags = f;
                return e;
            end
        endcase
        if (arith) begin
            r = s[W-1:0];
            c = s[W];
            v = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        end
        e.flags     = '0;
        e.flags[CB] = c;
        e.flags[ZB] = (r == '0);
        e.flags[NB] = r[W-1];
        e.flags[VB] = v;
        e.out       = (op == `ENUM_ALU_OPER_CMP) ? prev : r;
        return e;
    endfunction

    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    logic [W-1:0] prev_out = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic issue(input logic [OPW-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [FW-1:0] f);
        exp_t e;
        bus.start         = 1'b1;
        bus.oper          = op;
        bus.a_in          = a;
        bus.b_in          = b;
        bus.proc_flags_in = f;
        e = ref_model(op, a, b, f, prev_out);
        sb.push_back(e);
        prev_out = e.out;
        @(negedge master_clk);
        bus.start = 1'b0;
    endtask

    // Entered at the negedge of RUN cycle first_cycle; returns at the done negedge.
    task automatic wait_done(input string tag, input int first_cycle);
        int   cycles   = first_cycle;
        int   busy_cnt = 0;
        exp_t e;
        while (!bus.done && cycles < 20) begin
            if (bus.busy) busy_cnt++;
            @(negedge master_clk);
            cycles++;
        end
        check({tag, "_latency"}, cycles, NC + 1);
        check({tag, "_busy_cycles"}, busy_cnt, NC + 1 - first_cycle);
        check({tag, "_busy_in_done"}, bus.busy, 0);
        if (bus.done) begin
            check({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_out"}, bus.out, e.out);
                check({tag, "_flags"}, bus.proc_flags_out, e.flags);
            end
        end
    endtask

    logic [OPW-1:0] rand_ops [14];
    int             done_seen;

    initial begin
        rand_ops = '{`ENUM_ALU_OPER_ADD, `ENUM_ALU_OPER_ADC, `ENUM_ALU_OPER_SUB, `ENUM_ALU_OPER_SBC,
                     `ENUM_ALU_OPER_AND, `ENUM_ALU_OPER_ORR, `ENUM_ALU_OPER_XOR, `ENUM_ALU_OPER_CMP,
                     `ENUM_ALU_OPER_LSL, `ENUM_ALU_OPER_LSR, `ENUM_ALU_OPER_ASR, `ENUM_ALU_OPER_ROL,
                     `ENUM_ALU_OPER_ROR, 4'd14};
        bus.start = 1'b0; bus.oper = '0; bus.a_in = '0; bus.b_in = '0; bus.proc_flags_in = '0;
        repeat (2) @(negedge master_clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_out", bus.out, 0);
        check("rst_flags", bus.proc_flags_out, 0);
`ifdef ALU_PAIR_SEQ_START_ERR_EN
        check("rst_start_err", bus.start_err, 0);
`endif
        reset = 1'b0;
        @(negedge master_clk);

        issue(`ENUM_ALU_OPER_ADD, 16'h00FF, 16'h0001, 4'b0000);
        check("add_busy_c1", bus.busy, 1);
        wait_done("add", 1);
        check("add_out_const", bus.out, 16'h0100);
        check("add_flags_const", bus.proc_flags_out, 4'b0000);
        @(negedge master_clk);
        check("add_done_pulse", bus.done, 0);
        check("add_out_hold", bus.out, 16'h0100);

        issue(`ENUM_ALU_OPER_ADC, 16'hFFFF, 16'h0000, 4'b0001);
        wait_done("adc", 1);
        check("adc_out_const", bus.out, 16'h0000);
        check("adc_flags_const", bus.proc_flags_out, 4'b0011);
        @(negedge master_clk);

        issue(`ENUM_ALU_OPER_XOR, 16'hABCD, 16'h0000, 4'b0000);
        wait_done("xor_seed", 1);
        @(negedge master_clk);
        issue(`ENUM_ALU_OPER_CMP, 16'h1234, 16'h1234, 4'b0000);
        wait_done("cmp", 1);
        check("cmp_out_const", bus.out, 16'hABCD);
        check("cmp_flags_const", bus.proc_flags_out, 4'b0011);
        @(negedge master_clk);

        issue(`ENUM_ALU_OPER_LSL, 16'h8001, 16'h0000, 4'b0000);
        wait_done("lsl", 1);
        check("lsl_out_const", bus.out, 16'h0002);
        check("lsl_flags_const", bus.proc_flags_out, 4'b0001);
        @(negedge master_clk);
        issue(`ENUM_ALU_OPER_ASR, 16'h8002, 16'h0000, 4'b0000);
        wait_done("asr", 1);
        check("asr_out_const", bus.out, 16'hC001);
        check("asr_flags_const", bus.proc_flags_out, 4'b0100);

        // Back-to-back: the next start is raised in the DONE cycle.
        issue(`ENUM_ALU_OPER_ADD, 16'h1111, 16'h2222, 4'b0000);
        wait_done("b2b_add", 1);
        issue(`ENUM_ALU_OPER_XOR, 16'hF0F0, 16'hFFFF, 4'b0000);
        wait_done("b2b_xor", 1);
        check("b2b_xor_const", bus.out, 16'h0F0F);
        @(negedge master_clk);

        // start raised mid-RUN must not launch a second operation.
        issue(`ENUM_ALU_OPER_SUB, 16'h5000, 16'h1000, 4'b0000);
        bus.start = 1'b1; bus.oper = `ENUM_ALU_OPER_ADD; bus.a_in = 16'hFFFF; bus.b_in = 16'hFFFF;
        @(negedge master_clk);
        bus.start = 1'b0;
`ifdef ALU_PAIR_SEQ_START_ERR_EN
        check("start_err_pulse", bus.start_err, 1);
`endif
        wait_done("sub_ignored_start", 2);
        check("sub_out_const", bus.out, 16'h4000);
        @(negedge master_clk);
        check("ignored_no_run", bus.busy, 0);
        check("ignored_no_done", bus.done, 0);
`ifdef ALU_PAIR_SEQ_START_ERR_EN
        check("start_err_clear", bus.start_err, 0);
`endif

        issue(4'd15, 16'h1234, 16'h5678, 4'b1010);
        wait_done("undef", 1);
        check("undef_out_const", bus.out, 16'h0000);
        check("undef_flags_const", bus.proc_flags_out, 4'b1010);
        @(negedge master_clk);

        for (int i = 0; i < 10; i++) begin
            issue(rand_ops[$urandom_range(13, 0)], 16'($urandom), 16'($urandom), 4'($urandom));
            wait_done("rand", 1);
            @(negedge master_clk);
        end

        // Reset in the first RUN cycle aborts without a done pulse.
        issue(`ENUM_ALU_OPER_ADD, 16'h00FF, 16'h0001, 4'b0000);
        reset = 1'b1;
        @(negedge master_clk);
        reset = 1'b0;
        void'(sb.pop_back());
        prev_out = '0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_out", bus.out, 0);
        check("abort_flags", bus.proc_flags_out, 0);
        done_seen = 0;
        repeat (5) begin
            @(negedge master_clk);
            if (bus.done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
